// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter sharing the IN protocol engine data port among NUM_IN_EPS endpoints.
// Optional grant watchdog with a per-endpoint block mask is built when USB_IN_ARB_WDOG_EN is defined.
module usb_fs_in_rr_arb #(
  parameter int          NUM_IN_EPS     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_EPS-1:0]   in_ep_req,
  output logic [NUM_IN_EPS-1:0]   in_ep_grant,
  input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
  input  logic [NUM_IN_EPS-1:0]   in_ep_acked,
  output logic [7:0]              arb_in_ep_data,
  output logic                    arb_busy,
  output logic                    arb_timeout
);

  // state  | meaning
  // IDLE   | no owner, scan requests from r_rr_ptr
  // GRANT  | r_idx owns the port until req drop, ACK or watchdog
  // GAP    | one forced dead cycle between owners
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam int PW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;

  state_t                  r_state;
  logic [NUM_IN_EPS-1:0]   r_grant;
  logic [PW-1:0]           r_rr_ptr;
  logic [PW-1:0]           r_idx;
  logic                    r_busy;

  logic [NUM_IN_EPS-1:0]   w_eligible;
  logic                    w_found;
  logic [PW-1:0]           w_sel;
  logic [PW-1:0]           w_scan;
  logic                    w_release;
  logic                    w_timeout_hit;
  logic [PW-1:0]           w_next_ptr;
  logic [7:0]              w_data;

`ifdef USB_IN_ARB_WDOG_EN
  logic [15:0]             r_wcnt;
  logic [NUM_IN_EPS-1:0]   r_mask;
  logic                    r_timeout;

  assign w_eligible    = in_ep_req & ~r_mask;
  assign w_timeout_hit = (r_state == S_GRANT) && !w_release &&
                         (r_wcnt == TIMEOUT_CYCLES - 16'd1);

  // Mask bit clears once the endpoint is seen idle, so a stuck owner must toggle req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt    <= 16'd0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      r_mask    <= (r_mask & in_ep_req) |
                   (w_timeout_hit ? (NUM_IN_EPS'(1) << r_idx) : '0);
      if (r_state == S_IDLE && w_found)
        r_wcnt <= 16'd0;
      else if (r_state == S_GRANT)
        r_wcnt <= r_wcnt + 16'd1;
    end
  end

  assign arb_timeout = r_timeout;
`else
  assign w_eligible    = in_ep_req;
  assign w_timeout_hit = 1'b0;
  assign arb_timeout   = 1'b0;
`endif

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      w_scan = PW'((int'(r_rr_ptr) + i) % NUM_IN_EPS);
      if (!w_found && w_eligible[w_scan]) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
    end
  end

  assign w_release  = ~in_ep_req[r_idx] | in_ep_acked[r_idx];
  assign w_next_ptr = (r_idx == PW'(NUM_IN_EPS - 1)) ? '0 : r_idx + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= NUM_IN_EPS'(1) << w_sel;
            r_idx   <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release || w_timeout_hit) begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_GAP;
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_data = 8'h00;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (r_grant[i])
        w_data = w_data | in_ep_data[8*i +: 8];
    end
  end

  assign in_ep_grant    = r_grant;
  assign arb_busy       = r_busy;
  assign arb_in_ep_data = w_data;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Self-checking bench for usb_fs_in_rr_arb: owner/queue model checked every cycle plus directed checks.
// Watchdog scenarios are exercised when USB_IN_ARB_WDOG_EN is defined.
module tb_usb_fs_in_rr_arb;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef USB_IN_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int HOLD = WDOG ? 6 : 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  in_ep_req = '0;
  logic [N-1:0]  in_ep_grant;
  logic [N*8-1:0] in_ep_data = '0;
  logic [N-1:0]  in_ep_acked = '0;
  logic [7:0]    arb_in_ep_data;
  logic          arb_busy;
  logic          arb_timeout;

  int n_total = 0;
  int n_pass  = 0;

  usb_fs_in_rr_arb #(.NUM_IN_EPS(N), .TIMEOUT_CYCLES(16'(TO))) dut (
    .clk            (clk),
    .reset          (reset),
    .in_ep_req      (in_ep_req),
    .in_ep_grant    (in_ep_grant),
    .in_ep_data     (in_ep_data),
    .in_ep_acked    (in_ep_acked),
    .arb_in_ep_data (arb_in_ep_data),
    .arb_busy       (arb_busy),
    .arb_timeout    (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: current owner (-1 none), cooldown cycles left before arbitration resumes, next start index.
  int           m_own  = -1;
  int           m_cool = 0;
  int           m_ptr  = 0;
  int           m_cnt  = 0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_set;
  logic         m_to   = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_own = -1; m_cool = 0; m_ptr = 0; m_cnt = 0; m_mask = '0; m_to = 1'b0;
      end else begin
        m_set = '0;
        m_to  = 1'b0;
        if (m_own >= 0) begin
          if (!in_ep_req[m_own] || in_ep_acked[m_own]) begin
            m_ptr = (m_own + 1) % N; m_own = -1; m_cool = 2;
          end else begin
            m_cnt++;
            if (WDOG && m_cnt >= TO) begin
              m_set[m_own] = 1'b1; m_to = 1'b1;
              m_ptr = (m_own + 1) % N; m_own = -1; m_cool = 2;
            end
          end
        end else if (m_cool > 1) begin
          m_cool--;
        end else begin
          for (int i = 0; i < N; i++)
            if (m_own < 0 && in_ep_req[(m_ptr + i) % N] && !(WDOG && m_mask[(m_ptr + i) % N])) begin
              m_own = (m_ptr + i) % N; m_cnt = 0;
            end
        end
        m_mask = (m_mask & in_ep_req) | m_set;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("model_grant", 32'(in_ep_grant), (m_own >= 0) ? 32'(1 << m_own) : 32'd0);
        chk("model_busy", 32'(arb_busy), 32'(m_own >= 0));
        chk("model_data", 32'(arb_in_ep_data), (m_own >= 0) ? 32'(in_ep_data[m_own*8 +: 8]) : 32'd0);
        chk("model_timeout", 32'(arb_timeout), 32'(m_to));
      end
    end
  end

  logic [N-1:0] v_req [12] = '{4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b1010, 4'b1010,
                               4'b0000, 4'b1101, 4'b1101, 4'b0011, 4'b1000, 4'b0000};
  logic [N-1:0] v_ack [12] = '{4'b0000, 4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b1000,
                               4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b0010, 4'b0000};
  int           v_len [12] = '{3, 2, 4, 1, 5, 2, 3, 4, 1, 6, 3, 3};

  initial begin
    // reset held with all requesting
    in_ep_req = 4'b1111;
    tick(3);
    @(negedge clk);
    chk("rst_grant", 32'(in_ep_grant), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("first_grant", 32'(in_ep_grant), 32'b0001);

    // round robin, all four requesting
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(in_ep_grant), 32'(1 << (k % 4)));
      tick(HOLD - 1);
      in_ep_acked = 4'(1 << (k % 4));
      tick(1);
      in_ep_acked = '0;
      if (k == 4) in_ep_req = '0;
      @(negedge clk);
      chk("rr_gap0", 32'(in_ep_grant), 32'd0);
      tick(1);
      @(negedge clk);
      chk("rr_gap1", 32'(in_ep_grant), 32'd0);
      tick(1);
    end

    // EP2 data path, foreign ACK ignored
    in_ep_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_ep_req  = 4'b0100;
    tick(1);
    @(negedge clk);
    chk("ep2_grant", 32'(in_ep_grant), 32'b0100);
    chk("ep2_data", 32'(arb_in_ep_data), 32'hA5);
    chk("ep2_busy", 32'(arb_busy), 32'd1);
    in_ep_acked = 4'b0010;
    tick(1);
    in_ep_acked = '0;
    @(negedge clk);
    chk("foreign_ack", 32'(in_ep_grant), 32'b0100);
    in_ep_data[23:16] = 8'h5A;
    #1;
    chk("data_comb", 32'(arb_in_ep_data), 32'h5A);
    in_ep_req = '0;
    tick(1);
    @(negedge clk);
    chk("ep2_release", 32'(in_ep_grant), 32'd0);
    chk("idle_data", 32'(arb_in_ep_data), 32'd0);
    tick(2);

    // simultaneous drop and ACK on EP3, pointer wraps to 0
    in_ep_req = 4'b1001;
    tick(1);
    @(negedge clk);
    chk("ep3_grant", 32'(in_ep_grant), 32'b1000);
    tick(3);
    in_ep_req   = 4'b0001;
    in_ep_acked = 4'b1000;
    tick(1);
    in_ep_acked = '0;
    @(negedge clk);
    chk("ep3_release", 32'(in_ep_grant), 32'd0);
    tick(1);
    @(negedge clk);
    chk("ep3_gap", 32'(in_ep_grant), 32'd0);
    tick(1);
    @(negedge clk);
    chk("wrap_ep0", 32'(in_ep_grant), 32'b0001);
    in_ep_req = '0;
    tick(3);

    // async reset mid-grant on EP1
    in_ep_req = 4'b0010;
    tick(1);
    @(negedge clk);
    chk("ep1_grant", 32'(in_ep_grant), 32'b0010);
    in_ep_req = 4'b0011;
    tick(2);
    @(negedge clk);
    chk("no_preempt", 32'(in_ep_grant), 32'b0010);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_grant", 32'(in_ep_grant), 32'd0);
    chk("async_rst_busy", 32'(arb_busy), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_ptr0", 32'(in_ep_grant), 32'b0001);
    in_ep_req = '0;
    tick(3);

    // mixed directed vectors, checked by the model
    for (int v = 0; v < 12; v++) begin
      in_ep_data  = {8'h44, 8'h33, 8'h22, 8'h11} ^ {4{8'(v)}};
      in_ep_req   = v_req[v];
      in_ep_acked = v_ack[v];
      tick(1);
      in_ep_acked = '0;
      tick(v_len[v] - 1);
    end
    in_ep_req = '0;
    tick(4);

`ifdef USB_IN_ARB_WDOG_EN
    in_ep_req = 4'b0001;
    tick(1);
    @(negedge clk);
    chk("wd_grant", 32'(in_ep_grant), 32'b0001);
    tick(7);
    @(negedge clk);
    chk("wd_last_cycle", 32'(in_ep_grant), 32'b0001);
    chk("wd_no_pulse_yet", 32'(arb_timeout), 32'd0);
    tick(1);
    @(negedge clk);
    chk("wd_revoke", 32'(in_ep_grant), 32'd0);
    chk("wd_pulse", 32'(arb_timeout), 32'd1);
    in_ep_req = 4'b0011;
    tick(1);
    @(negedge clk);
    chk("wd_pulse_end", 32'(arb_timeout), 32'd0);
    tick(1);
    @(negedge clk);
    chk("wd_other", 32'(in_ep_grant), 32'b0010);
    in_ep_req = 4'b0001;
    tick(4);
    @(negedge clk);
    chk("wd_masked", 32'(in_ep_grant), 32'd0);
    in_ep_req = '0;
    tick(1);
    in_ep_req = 4'b0001;
    tick(1);
    @(negedge clk);
    chk("wd_unmask", 32'(in_ep_grant), 32'b0001);
    in_ep_req = '0;
    tick(3);
`else
    in_ep_req = 4'b0001;
    tick(1);
    @(negedge clk);
    chk("hold_grant", 32'(in_ep_grant), 32'b0001);
    tick(20);
    @(negedge clk);
    chk("hold_forever", 32'(in_ep_grant), 32'b0001);
    chk("no_timeout", 32'(arb_timeout), 32'd0);
    in_ep_req = '0;
    tick(3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
